// File: rtl/uart_bus_master_pkg.sv
// Shared constants and state encoding for the UART-driven bus initiator.
package uart_bus_master_pkg;
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam int         FRAME_LEN = 4;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ADDR   = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_BUS_WR = 3'd3;
  localparam state_t S_BUS_RD = 3'd4;
  localparam state_t S_RESP   = 3'd5;
  localparam state_t S_ERR    = 3'd6;
endpackage

// File: rtl/uart_bus_master_timeout.sv
// Inter-byte watchdog: reloads on clear, counts idle enabled cycles, pulses expired once.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)                          r_cnt <= '0;
    else if (clear)                     r_cnt <= W'(TIMEOUT_CYCLES);
    else if (enable && r_cnt != '0)     r_cnt <= r_cnt - W'(1);
  end

  // Fires in the TIMEOUT_CYCLES-th idle cycle; a byte in that cycle suppresses it.
  assign expired = enable && !clear && (r_cnt == W'(1));
endmodule

// File: rtl/uart_bus_master.sv
// Parses UART command frames into single-cycle bus reads/writes and returns ack or read data.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        err_overrun
);
  localparam logic [1:0] LAST = 2'(FRAME_LEN - 1);

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic        r_is_wr;
  logic [31:0] r_addr, r_wdata;
  logic [23:0] r_resp;
  logic        r_tx_en;
  logic [7:0]  r_tx_data;
  logic        r_err_overrun;

  logic w_in_frame, w_tmo_clear, w_expired, w_xfer, w_drop;

  assign w_in_frame  = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_tmo_clear = rx_valid || !w_in_frame;
  assign w_xfer      = r_tx_en && tx_ready;
  assign w_drop      = rx_valid && !w_in_frame && (r_state != S_IDLE);

  uart_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_tmo_clear),
    .enable  (w_in_frame),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_is_wr       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_resp        <= '0;
      r_tx_en       <= 1'b0;
      r_tx_data     <= '0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_drop) r_err_overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (rx_valid) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            r_is_wr <= (rx_data == OP_WR);
            r_cnt   <= '0;
            r_state <= S_ADDR;
          end else begin
            r_tx_data <= RSP_ERR;
            r_tx_en   <= 1'b1;
            r_state   <= S_ERR;
          end
        end
        S_ADDR: if (rx_valid) begin
          r_addr <= {r_addr[23:0], rx_data};
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == LAST) r_state <= r_is_wr ? S_DATA : S_BUS_RD;
        end else if (w_expired) begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        S_DATA: if (rx_valid) begin
          r_wdata <= {r_wdata[23:0], rx_data};
          r_cnt   <= r_cnt + 2'd1;
          if (r_cnt == LAST) r_state <= S_BUS_WR;
        end else if (w_expired) begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        S_BUS_WR: begin
          r_tx_data <= RSP_ACK;
          r_tx_en   <= 1'b1;
          r_state   <= S_RESP;
        end
        S_BUS_RD: begin
          r_tx_data <= rdata[31:24];
          r_resp    <= rdata[23:0];
          r_tx_en   <= 1'b1;
          r_state   <= S_RESP;
        end
        // Offer, transfer, one idle cycle, then offer the next byte.
        S_RESP: if (w_xfer) begin
          r_tx_en <= 1'b0;
          if (r_is_wr || r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end else if (!r_tx_en) begin
          r_tx_en   <= 1'b1;
          r_tx_data <= r_resp[23:16];
          r_resp    <= {r_resp[15:0], 8'h00};
        end
        S_ERR: if (w_xfer) begin
          r_tx_en <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_en       = r_tx_en;
  assign tx_data     = r_tx_data;
  assign rd          = (r_state == S_BUS_RD);
  assign wr          = (r_state == S_BUS_WR);
  assign addr        = r_addr;
  assign wdata       = r_wdata;
  assign busy        = (r_state != S_IDLE);
  assign err_overrun = r_err_overrun;
endmodule
